imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports CLK (in, 1, rising-edge clock) and resetl (in, 1, async active-low reset).
REQ-002 The block SHALL have these input ports:
- in_valid, in, 1: request valid.
- in_ready, out, 1: request accepted when in_valid and in_ready are both high.
- in_tmpl, in, 32: instruction template; all non-immediate fields.
- in_fmt, in, 2: format; 00 B (imm26 at [25:0]), 10 CB (imm19 at [23:5]), 11 D (imm9 at [20:12]), 01 illegal.
- in_sgn, in, 1: signed field for CB/D; ignored for B, which is always signed.
- in_imm, in, 64: immediate value, two's complement.
REQ-003 The block SHALL have these output ports:
- out_valid, out, 1: encoded word valid.
- out_ready, in, 1: consumer ready.
- out_inst, out, 32: encoded instruction word.
- out_err, out, 1: range or format error for out_inst.
- err_cnt, out, 8: saturating count of errored words delivered.

Function
REQ-004 Pipeline: S1 registers the request and range-check result; S2 registers the packed word. Latency from acceptance to out_valid SHALL be 2 cycles with no backpressure.
REQ-005 in_ready SHALL equal (!s1_valid || s1_adv), where s1_adv = (!s2_valid || out_ready). This gives full throughput of one word per cycle.
REQ-006 S2 SHALL hold out_inst, out_err and out_valid stable while out_valid && !out_ready.
REQ-007 Field width N SHALL be 26, 19 or 9 for formats 00, 10 or 11 respectively.
REQ-008 For a signed field, in_imm SHALL be in range iff in_imm[63:N-1] are all equal.
REQ-009 For an unsigned field, in_imm SHALL be in range iff in_imm[63:N] are all zero.
REQ-010 The packed word SHALL be in_tmpl with bits [31:30] forced to in_fmt and the immediate field replaced by in_imm[N-1:0]. All other template bits SHALL pass through unchanged.
REQ-011 On an out-of-range immediate or fmt=01, out_err SHALL be 1 and the immediate field SHALL be zero. The rest of the word SHALL be packed as in REQ-010; for fmt=01, out_inst SHALL equal in_tmpl unchanged.
REQ-012 err_cnt SHALL increment on each out_valid && out_ready && out_err cycle and SHALL saturate at 8'hFF.
REQ-013 Decoding out_inst with the CPU sign-extender (Ctrl = in_sgn) SHALL reproduce in_imm for every in-range request.
REQ-014 Boundary values SHALL be in range: for B, -2^25 and 2^25-1; for unsigned D, 0 and 511. Values one beyond each boundary SHALL be errors.

Reset
REQ-015 While resetl=0, s1_valid, out_valid, out_err and err_cnt SHALL be 0, out_inst SHALL be 32'h0 and in_ready SHALL be 1.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight words, with no partial delivery after release.
REQ-017 The first acceptance SHALL occur no earlier than the first rising CLK edge after resetl deasserts.

Structure
REQ-018 A shared package SHALL hold:
- format codes FMT_B=2'b00, FMT_CB=2'b10, FMT_D=2'b11;
- field widths W_B=26, W_CB=19, W_D=9;
- field LSB positions 0, 5 and 12.
REQ-019 The range check and packing SHALL be one combinational sub-module, imm_field_pack, instantiated once in S1/S2. All state SHALL reside in imm_encoder.

Verification
REQ-020 Test B pass-through:
- stimulus: fmt=00, imm=-1, tmpl=32'h14000000, out_ready=1;
- response: out_inst=32'h17FFFFFF, out_err=0, two cycles after acceptance.
REQ-021 Test CB range:
- stimulus: fmt=10, sgn=1, imm=262144 (2^18);
- response: out_err=1, bits [23:5]=0, err_cnt=1.
- stimulus: imm=262143;
- response: out_err=0, bits [23:5]=19'h3FFFF.
REQ-022 Test D unsigned:
- stimulus: fmt=11, sgn=0, imm=511;
- response: bits [20:12]=9'h1FF, no error.
- stimulus: imm=-1;
- response: out_err=1.
REQ-023 Test backpressure:
- stimulus: 4 back-to-back requests with out_ready=0 for 5 cycles;
- response: in_ready=0 after 2 accepts, out_inst held stable, all 4 delivered in order once ready.
REQ-024 Test reset mid-stream:
- stimulus: drop resetl with 2 words in flight;
- response: out_valid=0 immediately, nothing delivered after release, err_cnt=0.
REQ-025 Test saturation and illegal format:
- stimulus: 300 errored words;
- response: err_cnt=8'hFF.
- stimulus: fmt=01;
- response: out_err=1, out_inst=tmpl.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format codes, field geometry
// and the range-check helper used by the packer.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_B   = 2'b00,
        FMT_ILL = 2'b01,
        FMT_CB  = 2'b10,
        FMT_D   = 2'b11
    } fmt_e;

    localparam int unsigned W_B    = 26;
    localparam int unsigned W_CB   = 19;
    localparam int unsigned W_D    = 9;

    localparam int unsigned LSB_B  = 0;
    localparam int unsigned LSB_CB = 5;
    localparam int unsigned LSB_D  = 12;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_word_t;

    // Signed fields need imm[63:width-1] to be a pure sign extension;
    // unsigned fields need imm[63:width] to be zero.
    function automatic logic imm_fits(input logic [63:0] imm,
                                      input int unsigned width,
                                      input logic        is_signed);
        logic [63:0] hi;
        if (is_signed) begin
            hi = $unsigned($signed(imm) >>> (width - 1));
            return (hi == '0) || (hi == '1);
        end
        hi = imm >> width;
        return hi == '0;
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational range check and packing of one immediate into an instruction
// template. Holds no state.
module imm_field_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0] tmpl_i,
    input  logic [1:0]  fmt_i,
    input  logic        sgn_i,
    input  logic [63:0] imm_i,
    output logic [31:0] inst_o,
    output logic        err_o
);

    int unsigned width;
    int unsigned lsb;
    logic        is_signed;
    logic        legal;
    logic        fits;
    logic [31:0] field_mask;
    logic [31:0] field_val;

    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        width     = W_B;
        lsb       = LSB_B;
        is_signed = 1'b1;
        legal     = 1'b1;
        inst_o    = tmpl_i;
        err_o     = 1'b0;

        case (fmt_e'(fmt_i))
            FMT_B: begin
                width     = W_B;
                lsb       = LSB_B;
                is_signed = 1'b1;
            end
            FMT_CB: begin
                width     = W_CB;
                lsb       = LSB_CB;
                is_signed = sgn_i;
            end
            FMT_D: begin
                width     = W_D;
                lsb       = LSB_D;
                is_signed = sgn_i;
            end
            default: legal = 1'b0;
        endcase

        fits       = imm_fits(imm_i, width, is_signed);
        field_mask = ((32'h1 << width) - 32'h1) << lsb;
        field_val  = (imm_i[31:0] << lsb) & field_mask;

        // An illegal format leaves the template untouched; a range error
        // still stamps the format but zeroes the immediate field.
        if (!legal) begin
            inst_o = tmpl_i;
            err_o  = 1'b1;
        end else begin
            inst_o = {fmt_i, tmpl_i[29:0]} & ~field_mask;
            if (fits) begin
                inst_o = inst_o | field_val;
            end
            err_o = !fits;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder with valid/ready handshakes on both sides and a
// saturating count of errored words delivered.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        CLK,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_tmpl,
    input  logic [1:0]  in_fmt,
    input  logic        in_sgn,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    logic        s1_valid_q, s1_valid_d;
    enc_word_t   s1_word_q,  s1_word_d;
    logic        s2_valid_q, s2_valid_d;
    enc_word_t   s2_word_q,  s2_word_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    logic        s1_adv;
    logic [31:0] pack_inst;
    logic        pack_err;

    imm_field_pack u_pack (
        .tmpl_i (in_tmpl),
        .fmt_i  (in_fmt),
        .sgn_i  (in_sgn),
        .imm_i  (in_imm),
        .inst_o (pack_inst),
        .err_o  (pack_err)
    );

    assign s1_adv    = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s1_adv;

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_word_q.inst;
    assign out_err   = s2_word_q.err;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        err_cnt_d  = err_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_word_d = '{inst: pack_inst, err: pack_err};
            end
        end

        // S2 only moves when the consumer can take its word, so a stalled
        // output stays stable.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_word_d = s1_word_q;
            end
        end

        if (s2_valid_q && out_ready && s2_word_q.err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            err_cnt_q  <= 8'h00;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed requests push hand-computed
// words into a queue, a monitor pops and compares each delivered word.
module tb_imm_encoder;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_tmpl;
    logic [1:0]  in_fmt;
    logic        in_sgn;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    int   total = 0;
    int   bad   = 0;
    int   deliv = 0;
    exp_t sb[$];
    exp_t mon_e;

    imm_encoder dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tmpl   (in_tmpl),
        .in_fmt    (in_fmt),
        .in_sgn    (in_sgn),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after a rising edge; in_ready is sampled on the
    // falling edge so the accepting edge is known in advance.
    task automatic send(input logic [31:0] tmpl, input logic [1:0] fmt, input logic sgn,
                        input logic [63:0] imm, input logic [31:0] exp_inst, input logic exp_err);
        int n;
        in_valid = 1'b1;
        in_tmpl  = tmpl;
        in_fmt   = fmt;
        in_sgn   = sgn;
        in_imm   = imm;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        check("accept", {63'b0, in_ready}, 64'd1);
        if (in_ready) sb.push_back('{inst: exp_inst, err: exp_err});
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (resetl && out_valid && out_ready) begin
            deliv++;
            if (sb.size() == 0) begin
                check("unexpected_word", {63'b0, out_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("inst", {32'b0, out_inst}, {32'b0, mon_e.inst});
                check("err", {63'b0, out_err}, {63'b0, mon_e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        resetl    = 1'b0;
        in_valid  = 1'b0;
        in_tmpl   = '0;
        in_fmt    = '0;
        in_sgn    = 1'b0;
        in_imm    = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_err",   {63'b0, out_err},   64'd0);
        check("rst_out_inst",  {32'b0, out_inst},  64'd0);
        check("rst_err_cnt",   {56'b0, err_cnt},   64'd0);
        check("rst_in_ready",  {63'b0, in_ready},  64'd1);
        resetl = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;

        // B pass-through with two-cycle latency
        send(32'h1400_0000, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h17FF_FFFF, 1'b0);
        check("lat_s1_only", {63'b0, out_valid}, 64'd0);
        @(posedge CLK);
        #1;
        check("lat_out_valid", {63'b0, out_valid}, 64'd1);
        drain();

        // CB signed range edge
        send(32'h54FF_FFFF, 2'b10, 1'b1, 64'd262144, 32'h9400_001F, 1'b1);
        drain();
        check("cb_err_cnt", {56'b0, err_cnt}, 64'd1);
        send(32'h54FF_FFFF, 2'b10, 1'b1, 64'd262143,              32'h947F_FFFF, 1'b0);
        send(32'h54FF_FFFF, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFC_0000, 32'h9480_001F, 1'b0);

        // D unsigned boundaries
        send(32'h3FFF_FFFF, 2'b11, 1'b0, 64'd511,                 32'hFFFF_FFFF, 1'b0);
        send(32'h3FFF_FFFF, 2'b11, 1'b0, 64'd0,                   32'hFFE0_0FFF, 1'b0);
        send(32'h3FFF_FFFF, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFE0_0FFF, 1'b1);
        send(32'h3FFF_FFFF, 2'b11, 1'b0, 64'd512,                 32'hFFE0_0FFF, 1'b1);

        // B boundaries
        send(32'h0000_0000, 2'b00, 1'b0, 64'hFFFF_FFFF_FE00_0000, 32'h0200_0000, 1'b0);
        send(32'h0000_0000, 2'b00, 1'b0, 64'd33554431,            32'h01FF_FFFF, 1'b0);
        send(32'h0000_0000, 2'b00, 1'b0, 64'd33554432,            32'h0000_0000, 1'b1);
        send(32'h0000_0000, 2'b00, 1'b0, 64'hFFFF_FFFF_FDFF_FFFF, 32'h0000_0000, 1'b1);

        // D signed, then illegal format
        send(32'h0000_0000, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 32'hC010_0000, 1'b0);
        send(32'h0000_0000, 2'b11, 1'b1, 64'd256,                 32'hC000_0000, 1'b1);
        send(32'h1234_5678, 2'b01, 1'b0, 64'd5,                   32'h1234_5678, 1'b1);
        drain();
        check("err_cnt_7", {56'b0, err_cnt}, 64'd7);

        // Backpressure: output stalled while four requests arrive
        out_ready = 1'b0;
        fork
            begin
                send(32'h0, 2'b11, 1'b0, 64'd1, 32'hC000_1000, 1'b0);
                send(32'h0, 2'b11, 1'b0, 64'd2, 32'hC000_2000, 1'b0);
                send(32'h0, 2'b11, 1'b0, 64'd3, 32'hC000_3000, 1'b0);
                send(32'h0, 2'b11, 1'b0, 64'd4, 32'hC000_4000, 1'b0);
            end
            begin
                repeat (2) @(negedge CLK);
                repeat (3) begin
                    @(negedge CLK);
                    check("bp_in_ready",  {63'b0, in_ready},  64'd0);
                    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
                    check("bp_hold_inst", {32'b0, out_inst},  64'hC000_1000);
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send(32'h0, 2'b11, 1'b0, 64'd5, 32'hC000_5000, 1'b0);
        send(32'h0, 2'b00, 1'b0, 64'd33554432, 32'h0000_0000, 1'b1);
        resetl = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_out_inst",  {32'b0, out_inst},  64'd0);
        check("mid_rst_err_cnt",   {56'b0, err_cnt},   64'd0);
        check("mid_rst_in_ready",  {63'b0, in_ready},  64'd1);
        sb.delete();
        repeat (2) @(negedge CLK);
        out_ready = 1'b1;
        resetl = 1'b1;
        @(posedge CLK);
        #1;
        base = deliv;
        repeat (10) @(negedge CLK);
        check("no_delivery_after_reset", 64'(deliv - base), 64'd0);
        check("err_cnt_after_reset", {56'b0, err_cnt}, 64'd0);
        @(posedge CLK);
        #1;

        // Saturation with 300 errored words, then illegal format once more
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0)
                send(32'hA5A5_0000, 2'b01, 1'b0, 64'd0, 32'hA5A5_0000, 1'b1);
            else
                send(32'h0, 2'b00, 1'b0, 64'd33554432, 32'h0000_0000, 1'b1);
        end
        drain();
        check("err_cnt_sat", {56'b0, err_cnt}, 64'hFF);
        send(32'hDEAD_BEEF, 2'b01, 1'b1, 64'd7, 32'hDEAD_BEEF, 1'b1);
        drain();
        check("err_cnt_held", {56'b0, err_cnt}, 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
